// File: rtl/id_stage_hzd.sv
// Decode stage: 32-entry register file with write-first bypass, load-use hazard
// detection, and the ID/EX pipeline register with flush/stall bubble insertion.
module id_stage_hzd #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 9,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_in,
  input  logic              n_rst_in,
  input  logic [31:0]       IFID_pc_in,
  input  logic [31:0]       IFID_ir_in,
  input  logic              IFID_valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              mem_read_in,
  input  logic              flush_in,
  input  logic [4:0]        wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              wb_we_in,
  output logic              stall_out,
  output logic [31:0]       IDEX_pc_out,
  output logic [31:0]       IDEX_ir_out,
  output logic [DATA_W-1:0] IDEX_a_out,
  output logic [DATA_W-1:0] IDEX_b_out,
  output logic [CTRL_W-1:0] IDEX_ctrl_out,
  output logic              IDEX_mem_read_out,
  output logic              IDEX_valid_out,
  output logic [15:0]       stall_count_out
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] rf_q [32];
  logic [DATA_W-1:0] rf_d [32];

  logic [31:0]       idex_pc_q,    idex_pc_d;
  logic [31:0]       idex_ir_q,    idex_ir_d;
  logic [DATA_W-1:0] idex_a_q,     idex_a_d;
  logic [DATA_W-1:0] idex_b_q,     idex_b_d;
  logic [CTRL_W-1:0] idex_ctrl_q,  idex_ctrl_d;
  logic              idex_mr_q,    idex_mr_d;
  logic              idex_valid_q, idex_valid_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic [4:0]        rs, rt, ld_rt;
  logic              wb_ok, hazard, stall;
  logic [DATA_W-1:0] op_a, op_b;

  assign rs    = IFID_ir_in[25:21];
  assign rt    = IFID_ir_in[20:16];
  assign ld_rt = idex_ir_q[20:16];

  // Operand read with write-back bypass; r0 is hardwired when ZERO_EN
  always_comb begin
    wb_ok = wb_we_in & ~(ZERO_EN & (wb_addr_in == 5'd0));
    if (ZERO_EN && (rs == 5'd0)) begin
      op_a = '0;
    end else if (wb_ok && (wb_addr_in == rs)) begin
      op_a = wb_data_in;
    end else begin
      op_a = rf_q[rs];
    end
    if (ZERO_EN && (rt == 5'd0)) begin
      op_b = '0;
    end else if (wb_ok && (wb_addr_in == rt)) begin
      op_b = wb_data_in;
    end else begin
      op_b = rf_q[rt];
    end
  end

  // Register-file next state; writes ignore stall and flush
  always_comb begin
    rf_d = rf_q;
    if (wb_ok) begin
      rf_d[wb_addr_in] = wb_data_in;
    end else begin
      rf_d[wb_addr_in] = rf_q[wb_addr_in];
    end
  end

  assign hazard    = idex_valid_q & idex_mr_q & IFID_valid_in & (ld_rt != 5'd0) &
                     ((ld_rt == rs) | (ld_rt == rt));
  assign stall     = hazard & ~flush_in;
  assign stall_out = stall;

  // ID/EX next state: flush and stall both inject a fully cleared bubble
  always_comb begin
    idex_pc_d     = IFID_pc_in;
    idex_ir_d     = IFID_ir_in;
    idex_a_d      = op_a;
    idex_b_d      = op_b;
    idex_ctrl_d   = IFID_valid_in ? ctrl_in : '0;
    idex_mr_d     = IFID_valid_in & mem_read_in;
    idex_valid_d  = IFID_valid_in;
    stall_count_d = stall_count_q;
    if (flush_in || stall) begin
      idex_pc_d    = 32'd0;
      idex_ir_d    = 32'd0;
      idex_a_d     = '0;
      idex_b_d     = '0;
      idex_ctrl_d  = '0;
      idex_mr_d    = 1'b0;
      idex_valid_d = 1'b0;
    end else begin
      idex_valid_d = IFID_valid_in;
    end
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      rf_q          <= '{default: '0};
      idex_pc_q     <= 32'd0;
      idex_ir_q     <= 32'd0;
      idex_a_q      <= '0;
      idex_b_q      <= '0;
      idex_ctrl_q   <= '0;
      idex_mr_q     <= 1'b0;
      idex_valid_q  <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      rf_q          <= rf_d;
      idex_pc_q     <= idex_pc_d;
      idex_ir_q     <= idex_ir_d;
      idex_a_q      <= idex_a_d;
      idex_b_q      <= idex_b_d;
      idex_ctrl_q   <= idex_ctrl_d;
      idex_mr_q     <= idex_mr_d;
      idex_valid_q  <= idex_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign IDEX_pc_out       = idex_pc_q;
  assign IDEX_ir_out       = idex_ir_q;
  assign IDEX_a_out        = idex_a_q;
  assign IDEX_b_out        = idex_b_q;
  assign IDEX_ctrl_out     = idex_ctrl_q;
  assign IDEX_mem_read_out = idex_mr_q;
  assign IDEX_valid_out    = idex_valid_q;
  assign stall_count_out   = stall_count_q;

endmodule

// File: doc/id_stage_hzd.md
ID_STAGE_HZD -- requirements
Module: id_stage_hzd

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file entries and of IDEX_a_out/IDEX_b_out.
REQ-002 Parameter CTRL_W, default 9, width of the opaque decoded-control bundle carried to EX.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 always reads 0 and ignores writes.
REQ-004 Ports (name  direction  width  meaning):
 clk_in  in  1  clock; all state updates on rising edge
 n_rst_in  in  1  reset, asynchronous, active-low
 IFID_pc_in  in  32  PC of decoding instruction
 IFID_ir_in  in  32  instruction; rs=[25:21], rt=[20:16]
 IFID_valid_in  in  1  IF/ID slot holds a real instruction
 ctrl_in  in  CTRL_W  decoder control bundle for IFID_ir_in
 mem_read_in  in  1  decoded instruction is a load (writes rt)
 flush_in  in  1  branch taken in EX; squash decoding instruction
 wb_addr_in  in  5  write-back register address
 wb_data_in  in  DATA_W  write-back data
 wb_we_in  in  1  write-back enable
 stall_out  out  1  load-use hazard; IF and IF/ID must hold
 IDEX_pc_out  out  32  registered PC
 IDEX_ir_out  out  32  registered instruction
 IDEX_a_out  out  DATA_W  registered rs operand
 IDEX_b_out  out  DATA_W  registered rt operand
 IDEX_ctrl_out  out  CTRL_W  registered control bundle
 IDEX_mem_read_out  out  1  registered load flag
 IDEX_valid_out  out  1  ID/EX slot holds a real instruction
 stall_count_out  out  16  saturating count of stall cycles

Function
REQ-005 Register file: 32 entries x DATA_W; write on rising edge when wb_we_in=1 at wb_addr_in.
REQ-006 Read with write-first bypass: if wb_we_in=1 and wb_addr_in equals read address (and is not reg 0 with ZERO_REG=1), operand = wb_data_in.
REQ-007 ZERO_REG=1: reads of reg 0 return 0; writes to reg 0 have no effect.
REQ-008 hazard = IDEX_valid_out & IDEX_mem_read_out & IFID_valid_in & (IDEX_ir_out[20:16] != 0) & (IDEX_ir_out[20:16] == rs or == rt).
REQ-009 stall_out = hazard & ~flush_in, combinational.
REQ-010 ID/EX update priority per rising edge: flush_in > stall_out > normal load.
REQ-011 Normal: IDEX_* <= IFID_pc_in, IFID_ir_in, bypassed operands, ctrl_in, mem_read_in, IFID_valid_in; latency one cycle.
REQ-012 Bubble (flush_in=1 or stall_out=1): IDEX_valid_out, IDEX_ctrl_out, IDEX_mem_read_out, IDEX_ir_out, IDEX_pc_out, IDEX_a_out, IDEX_b_out all <= 0.
REQ-013 IFID_valid_in=0 without flush/stall: fields loaded as normal, IDEX_valid_out=0, IDEX_ctrl_out and IDEX_mem_read_out <= 0.
REQ-014 Load-use stall lasts exactly one cycle: after the bubble IDEX_valid_out=0, so hazard deasserts and held instruction loads next edge.
REQ-015 Register-file write proceeds regardless of stall/flush.
REQ-016 stall_count_out increments by 1 each rising edge with stall_out=1; saturates at 16'hFFFF (no wrap).

Reset
REQ-017 n_rst_in=0 asynchronously clears all IDEX_* outputs, stall_count_out and all 32 registers to 0; stall_out therefore 0.
REQ-018 Reset asserted mid-stall cancels the stall; first edge after release performs a normal load.

Verification
REQ-019 Write r5=0x1234 then decode rs=5 -> IDEX_a_out=0x1234 one cycle later.
REQ-020 Same-edge wb to r7=0xCAFE while decoding rt=7 -> IDEX_b_out=0xCAFE (bypass).
REQ-021 lw writing r3 in ID/EX, next instr rs=3 -> stall_out=1 one cycle, bubble (valid=0) in ID/EX, then instr loads, stall_count_out=1.
REQ-022 Same hazard with flush_in=1 -> stall_out=0, ID/EX bubble, stall_count_out unchanged.
REQ-023 Write r0=0xFFFF, decode rs=0 (ZERO_REG=1) -> IDEX_a_out=0; lw to r0 followed by use of r0 -> no stall.
REQ-024 Force 65536 stall cycles -> stall_count_out holds 0xFFFF; pulse n_rst_in -> all outputs 0.
